// File: rtl/textmode_pkg.sv
// -----------------------------------------------------------------------------
// textmode_pkg
// Shared definitions for the text-mode cell RAM (TRAM) command sequencer.
//   - Display mode 3 geometry defaults (84 x 24 cells).
//   - Command opcode encoding carried on cmd_op.
//   - Sequencer FSM state encoding.
//   - cell_count(): number of cells on the screen, used for address limits.
// -----------------------------------------------------------------------------
package textmode_pkg;

  // Mode 3 geometry: 672x384 pixels with 8x16 glyphs.
  localparam int TEXT_W_MODE3 = 84;
  localparam int TEXT_H_MODE3 = 24;

  // cmd_op encoding
  localparam logic [1:0] OP_NOP    = 2'd0;
  localparam logic [1:0] OP_CLEAR  = 2'd1;
  localparam logic [1:0] OP_FILL   = 2'd2;
  localparam logic [1:0] OP_SCROLL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SCRL,
    ST_DRAIN,
    ST_BLANK,
    ST_FIN
  } state_e;

  function automatic int cell_count(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/textmode_wr_arb.sv
// -----------------------------------------------------------------------------
// textmode_wr_arb
// Registered 2:1 mux in front of the single TRAM write port.
//
// Host writes are only granted while the sequencer is idle, unless the
// build defines TEXTMODE_CTRL_HOSTPRI_EN, in which case the host always wins
// and the engine is told to stall for that cycle.
// Host writes to addresses outside the screen are accepted but dropped.
//
// Ports
//   clk_sys, rst_sys        clock / synchronous active-high reset
//   idle_i                  sequencer is in IDLE
//   eng_we_i/addr_i/din_i   engine write request for this cycle
//   host_we_i/addr_i/din_i  host single-cell write request
//   host_ready_o            host write accepted when host_we_i & host_ready_o
//   stall_o                 engine request not taken this cycle; hold state
//   ram_we_o/waddr_o/din_o  registered TRAM write port
// -----------------------------------------------------------------------------
module textmode_wr_arb
  import textmode_pkg::*;
#(
  parameter int TEXT_W = TEXT_W_MODE3,
  parameter int TEXT_H = TEXT_H_MODE3,
  parameter int ADDRW  = 11,
  parameter int WORDW  = 32
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  input  logic             idle_i,
  input  logic             eng_we_i,
  input  logic [ADDRW-1:0] eng_addr_i,
  input  logic [WORDW-1:0] eng_din_i,
  input  logic             host_we_i,
  input  logic [ADDRW-1:0] host_addr_i,
  input  logic [WORDW-1:0] host_din_i,
  output logic             host_ready_o,
  output logic             stall_o,
  output logic             ram_we_o,
  output logic [ADDRW-1:0] ram_waddr_o,
  output logic [WORDW-1:0] ram_din_o
);

  localparam int               CELLS   = cell_count(TEXT_W, TEXT_H);
  localparam logic [ADDRW:0]   CELLS_X = (ADDRW+1)'(CELLS);

  logic             we_q, we_d;
  logic [ADDRW-1:0] waddr_q, waddr_d;
  logic [WORDW-1:0] din_q, din_d;
  logic             host_acc;
  logic             host_hit;

`ifdef TEXTMODE_CTRL_HOSTPRI_EN
  assign host_ready_o = 1'b1;
`else
  assign host_ready_o = idle_i;
`endif

  assign host_acc = host_we_i & host_ready_o;
  // Out-of-range host addresses still complete the handshake but never write.
  assign host_hit = host_acc & ({1'b0, host_addr_i} < CELLS_X);
  // Any accepted host write during an op costs the engine one cycle, even a
  // dropped one, so the stall rule does not depend on the address.
  assign stall_o  = host_acc & ~idle_i;

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    din_d   = din_q;
    if (host_hit) begin
      we_d    = 1'b1;
      waddr_d = host_addr_i;
      din_d   = host_din_i;
    end else if (eng_we_i && !stall_o) begin
      we_d    = 1'b1;
      waddr_d = eng_addr_i;
      din_d   = eng_din_i;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      din_q   <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      din_q   <= din_d;
    end
  end

  assign ram_we_o    = we_q;
  assign ram_waddr_o = waddr_q;
  assign ram_din_o   = din_q;

endmodule

// File: rtl/textmode_ctrl.sv
// -----------------------------------------------------------------------------
// textmode_ctrl
// Command sequencer for the text-mode cell RAM (TRAM). Runs CLEAR, FILL and
// SCROLL_UP one cell per cycle and shares the single TRAM write port with a
// host single-cell write port through textmode_wr_arb.
//
// Build option: TEXTMODE_CTRL_HOSTPRI_EN
//   undefined - host writes only accepted while idle (host_ready=0 when busy)
//   defined   - host writes always accepted; the engine stalls one cycle for
//               each host write taken during an op
//
// Ports
//   clk_sys, rst_sys      clock / synchronous active-high reset
//   cmd_valid/ready       command handshake
//   cmd_op, cmd_data      opcode (NOP/CLEAR/FILL/SCROLL_UP) and fill word
//   host_we/addr/din      host cell write, host_ready handshake
//   ram_raddr, ram_dout   TRAM read port (data one cycle after address)
//   ram_we/waddr/din      TRAM write port (registered)
//   busy, done            op in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module textmode_ctrl
  import textmode_pkg::*;
#(
  parameter int               TEXT_W   = TEXT_W_MODE3,
  parameter int               TEXT_H   = TEXT_H_MODE3,
  parameter int               ADDRW    = 11,   // 2**ADDRW must cover TEXT_W*TEXT_H
  parameter int               WORDW    = 32,
  parameter logic [WORDW-1:0] CLR_WORD = '0
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WORDW-1:0] cmd_data,
  input  logic             host_we,
  input  logic [ADDRW-1:0] host_addr,
  input  logic [WORDW-1:0] host_din,
  output logic             host_ready,
  output logic [ADDRW-1:0] ram_raddr,
  input  logic [WORDW-1:0] ram_dout,
  output logic             ram_we,
  output logic [ADDRW-1:0] ram_waddr,
  output logic [WORDW-1:0] ram_din,
  output logic             busy,
  output logic             done
);

  localparam int               CELLS      = cell_count(TEXT_W, TEXT_H);
  localparam logic [ADDRW-1:0] LAST_ADDR  = ADDRW'(CELLS - 1);
  localparam logic [ADDRW-1:0] BLANK_BASE = ADDRW'((TEXT_H - 1) * TEXT_W);
  localparam logic [ADDRW-1:0] ROW_OFS    = ADDRW'(TEXT_W);

  state_e           state_q;
  logic [ADDRW-1:0] cnt_q;       // write address for FILL and BLANK
  logic [ADDRW-1:0] raddr_q;     // source address being read in SCRL
  logic             cp_vld_q;    // a copy is pending: ram_dout holds its data
  logic [ADDRW-1:0] cp_addr_q;   // destination of the pending copy
  logic [WORDW-1:0] fill_q;
  logic             busy_q;
  logic             done_q;

  logic             idle;
  logic             stall;
  logic             eng_we;
  logic [ADDRW-1:0] eng_addr;
  logic [WORDW-1:0] eng_din;

  assign idle = (state_q == ST_IDLE);

  // Engine write request for the current cycle.
  always_comb begin
    eng_we   = 1'b0;
    eng_addr = cnt_q;
    eng_din  = fill_q;
    case (state_q)
      ST_FILL: begin
        eng_we = 1'b1;
      end
      ST_SCRL, ST_DRAIN: begin
        eng_we   = cp_vld_q;
        eng_addr = cp_addr_q;
        eng_din  = ram_dout;
      end
      ST_BLANK: begin
        eng_we  = 1'b1;
        eng_din = CLR_WORD;
      end
      default: ;
    endcase
  end

  textmode_wr_arb #(
    .TEXT_W (TEXT_W),
    .TEXT_H (TEXT_H),
    .ADDRW  (ADDRW),
    .WORDW  (WORDW)
  ) u_wr_arb (
    .clk_sys      (clk_sys),
    .rst_sys      (rst_sys),
    .idle_i       (idle),
    .eng_we_i     (eng_we),
    .eng_addr_i   (eng_addr),
    .eng_din_i    (eng_din),
    .host_we_i    (host_we),
    .host_addr_i  (host_addr),
    .host_din_i   (host_din),
    .host_ready_o (host_ready),
    .stall_o      (stall),
    .ram_we_o     (ram_we),
    .ram_waddr_o  (ram_waddr),
    .ram_din_o    (ram_din)
  );

  // While stalled with a copy pending, re-read that copy's source so that
  // ram_dout still carries its data when the engine resumes next cycle.
  assign ram_raddr = (stall && cp_vld_q) ? (cp_addr_q + ROW_OFS) : raddr_q;

  assign cmd_ready = idle;
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      raddr_q   <= '0;
      cp_vld_q  <= 1'b0;
      cp_addr_q <= '0;
      fill_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!stall) begin
        case (state_q)
          ST_IDLE: begin
            if (cmd_valid) begin
              case (cmd_op)
                OP_NOP: ;
                OP_CLEAR, OP_FILL: begin
                  fill_q  <= (cmd_op == OP_FILL) ? cmd_data : CLR_WORD;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_FILL;
                end
                OP_SCROLL: begin
                  raddr_q  <= ROW_OFS;
                  cp_vld_q <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= ST_SCRL;
                end
              endcase
            end
          end

          ST_FILL: begin
            if (cnt_q == LAST_ADDR) begin
              state_q <= ST_FIN;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end

          // Read row r+1 while writing back what was read last cycle to row r.
          ST_SCRL: begin
            cp_vld_q  <= 1'b1;
            cp_addr_q <= raddr_q - ROW_OFS;
            if (raddr_q == LAST_ADDR) begin
              state_q <= ST_DRAIN;
            end else begin
              raddr_q <= raddr_q + 1'b1;
            end
          end

          ST_DRAIN: begin
            cp_vld_q <= 1'b0;
            cnt_q    <= BLANK_BASE;
            state_q  <= ST_BLANK;
          end

          ST_BLANK: begin
            if (cnt_q == LAST_ADDR) begin
              state_q <= ST_FIN;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end

          // The last write is on the TRAM port now; the op is complete.
          ST_FIN: begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_textmode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_textmode_ctrl
// Self-checking bench for textmode_ctrl. A behavioural TRAM sits on the RAM
// ports; expected screen contents are computed from the operation rules.
// -----------------------------------------------------------------------------
module tb_textmode_ctrl;

  localparam int W     = 84;
  localparam int H     = 24;
  localparam int N     = W * H;
  localparam int ADDRW = 11;
  localparam int WORDW = 32;

`ifdef TEXTMODE_CTRL_HOSTPRI_EN
  localparam bit HOST_RDY_BUSY = 1'b1;
  localparam int EXTRA         = 3;
`else
  localparam bit HOST_RDY_BUSY = 1'b0;
  localparam int EXTRA         = 0;
`endif

  logic             clk_sys = 1'b0;
  logic             rst_sys = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'd0;
  logic [WORDW-1:0] cmd_data = '0;
  logic             host_we = 1'b0;
  logic [ADDRW-1:0] host_addr = '0;
  logic [WORDW-1:0] host_din = '0;
  logic             host_ready;
  logic [ADDRW-1:0] ram_raddr;
  logic [WORDW-1:0] ram_dout;
  logic             ram_we;
  logic [ADDRW-1:0] ram_waddr;
  logic [WORDW-1:0] ram_din;
  logic             busy;
  logic             done;

  always #5 clk_sys = ~clk_sys;

  textmode_ctrl dut (
    .clk_sys    (clk_sys),
    .rst_sys    (rst_sys),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_din   (host_din),
    .host_ready (host_ready),
    .ram_raddr  (ram_raddr),
    .ram_dout   (ram_dout),
    .ram_we     (ram_we),
    .ram_waddr  (ram_waddr),
    .ram_din    (ram_din),
    .busy       (busy),
    .done       (done)
  );

  // Behavioural TRAM: simple dual port, registered read.
  logic [WORDW-1:0] mem [0:2047];
  int               wr_cnt [0:2047];
  int               tot_wr = 0;

  always @(posedge clk_sys) begin
    if (ram_we) begin
      mem[ram_waddr]    <= ram_din;
      wr_cnt[ram_waddr] <= wr_cnt[ram_waddr] + 1;
      tot_wr            <= tot_wr + 1;
    end
    ram_dout <= mem[ram_raddr];
  end

  // Reference data
  logic [WORDW-1:0] exp_mem [0:N-1];
  logic [WORDW-1:0] pre [0:N-1];
  int               base_wr [0:N-1];
  int               base_tot;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic snap();
    for (int i = 0; i < N; i++) base_wr[i] = wr_cnt[i];
    base_tot = tot_wr;
  endtask

  task automatic cmp_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== exp_mem[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic cmp_once(input string tag);
    int bad = 0;
    for (int i = 0; i < N; i++) if (wr_cnt[i] - base_wr[i] != 1) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_ready"},  cmd_ready, 1);
    chk({tag, "_host_ready"}, host_ready, 1);
    chk({tag, "_busy"},       busy, 0);
    chk({tag, "_done"},       done, 0);
    chk({tag, "_ram_we"},     ram_we, 0);
    chk({tag, "_ram_waddr"},  ram_waddr, 0);
    chk({tag, "_ram_raddr"},  ram_raddr, 0);
    chk({tag, "_ram_din"},    ram_din, 0);
  endtask

  function automatic logic [WORDW-1:0] inj_data(input int k);
    return 32'hA5A5_0000 | WORDW'(k);
  endfunction

  // Single host write while idle; checks the registered write one cycle later.
  task automatic host_wr_idle(input int addr, input logic [WORDW-1:0] data);
    host_we   = 1'b1;
    host_addr = ADDRW'(addr);
    host_din  = data;
    chk("host_ready_idle", host_ready, 1);
    @(negedge clk_sys);
    host_we = 1'b0;
    if (addr < N) begin
      chk("host_we", ram_we, 1);
      chk("host_waddr", ram_waddr, addr);
      chk("host_din", ram_din, data);
    end else begin
      chk("host_oor_we", ram_we, 0);
    end
    $display("host write addr=%0d data=0x%08h", addr, data);
  endtask

  // Issues one command from a negedge and follows it until done (bounded).
  task automatic run_op(input logic [1:0] op, input logic [WORDW-1:0] data,
                        input bit hold, input bit inject,
                        output int busy_n, output int done_k, output int first_we,
                        output int seq_bad, output int rdy_bad);
    int nexp;
    busy_n = 0; done_k = 0; first_we = 0; seq_bad = 0; rdy_bad = 0; nexp = 0;
    snap();
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    for (int k = 1; k <= 3000 && done_k == 0; k++) begin
      @(negedge clk_sys);
      if (busy) begin
        busy_n++;
        if (cmd_ready) rdy_bad++;
        if (host_ready !== HOST_RDY_BUSY) rdy_bad++;
      end
      if (ram_we) begin
        if (first_we == 0) first_we = k;
        if (ram_waddr != ADDRW'(nexp)) seq_bad++;
        nexp++;
      end
      if (done) done_k = k;
      if (!hold || done) cmd_valid = 1'b0;
      host_we   = inject && (k == 500 || k == 600 || k == 700);
      host_addr = ADDRW'(k / 100 - 4);
      host_din  = inj_data(k);
    end
    cmd_valid = 1'b0;
    host_we   = 1'b0;
    $display("op=%0d data=0x%08h busy=%0d done_at=%0d writes=%0d",
             op, data, busy_n, done_k, tot_wr - base_tot);
  endtask

  int busy_n, done_k, first_we, seq_bad, rdy_bad, cnt;
  logic [WORDW-1:0] fill_val;

  initial begin
    // ---------------- reset
    repeat (3) @(negedge clk_sys);
    chk_reset("rst");
    rst_sys = 1'b0;
    @(negedge clk_sys);

    // ---------------- host writes in IDLE
    host_wr_idle(5, 32'h1234);
    host_wr_idle(N, 32'h5555_AAAA);
    host_wr_idle(N - 1, 32'h0BAD_F00D);
    host_wr_idle(2047, 32'h7777_7777);
    for (int i = 0; i < 8; i++) host_wr_idle(int'($urandom_range(0, 2047)), $urandom);

    // ---------------- NOP
    cmd_op = 2'd0; cmd_valid = 1'b1;
    @(negedge clk_sys);
    cmd_valid = 1'b0;
    cnt = 0;
    repeat (4) begin
      if (busy || done) cnt++;
      @(negedge clk_sys);
    end
    chk("nop_no_effect", cnt, 0);
    $display("nop issued");

    // ---------------- CLEAR
    run_op(2'd1, $urandom, 1'b0, 1'b0, busy_n, done_k, first_we, seq_bad, rdy_bad);
    chk("clr_first_we", first_we, 2);
    chk("clr_busy_len", busy_n, N + 1);
    chk("clr_done_at", done_k, N + 2);
    chk("clr_seq", seq_bad, 0);
    chk("clr_ready", rdy_bad, 0);
    chk("clr_writes", tot_wr - base_tot, N);
    cmp_once("clr_once");
    for (int i = 0; i < N; i++) exp_mem[i] = '0;
    cmp_mem("clr_mem");
    @(negedge clk_sys);
    chk("clr_done_pulse", done, 0);

    // ---------------- FILL with cmd_valid held through busy
    run_op(2'd2, 32'hDEAD_BEEF, 1'b1, 1'b0, busy_n, done_k, first_we, seq_bad, rdy_bad);
    chk("fill_busy_len", busy_n, N + 1);
    chk("fill_done_at", done_k, N + 2);
    chk("fill_ready", rdy_bad, 0);
    chk("fill_writes", tot_wr - base_tot, N);
    for (int i = 0; i < N; i++) exp_mem[i] = 32'hDEAD_BEEF;
    cmp_mem("fill_mem");
    @(negedge clk_sys);
    chk("fill_not_reaccepted", busy, 0);

    // ---------------- FILL with random word
    fill_val = $urandom;
    run_op(2'd2, fill_val, 1'b0, 1'b0, busy_n, done_k, first_we, seq_bad, rdy_bad);
    chk("fill2_done_at", done_k, N + 2);
    chk("fill2_seq", seq_bad, 0);
    for (int i = 0; i < N; i++) exp_mem[i] = fill_val;
    cmp_mem("fill2_mem");

    // ---------------- preload through the host port, then SCROLL_UP
    for (int i = 0; i < N; i++) begin
      pre[i]    = $urandom;
      host_we   = 1'b1;
      host_addr = ADDRW'(i);
      host_din  = pre[i];
      @(negedge clk_sys);
    end
    host_we = 1'b0;
    repeat (2) @(negedge clk_sys);
    for (int i = 0; i < N; i++) exp_mem[i] = pre[i];
    cmp_mem("preload_mem");

    run_op(2'd3, $urandom, 1'b0, 1'b1, busy_n, done_k, first_we, seq_bad, rdy_bad);
    chk("scrl_busy_len", busy_n, (H - 1) * W + 1 + W + 1 + EXTRA);
    chk("scrl_done_at", done_k, (H - 1) * W + W + 3 + EXTRA);
    chk("scrl_ready", rdy_bad, 0);
    chk("scrl_writes", tot_wr - base_tot, N + EXTRA);
    for (int i = 0; i < N; i++) exp_mem[i] = (i < N - W) ? pre[i + W] : '0;
    if (EXTRA != 0) begin
      exp_mem[1] = inj_data(500);
      exp_mem[2] = inj_data(600);
      exp_mem[3] = inj_data(700);
    end
    cmp_mem("scrl_mem");
    @(negedge clk_sys);
    chk("scrl_done_pulse", done, 0);

    // ---------------- reset in the middle of a CLEAR
    cmd_op = 2'd1; cmd_valid = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk_sys);
      cmd_valid = 1'b0;
    end
    chk("midop_busy", busy, 1);
    rst_sys = 1'b1;
    @(negedge clk_sys);
    chk_reset("midrst");
    rst_sys = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk_sys);
      if (done || busy) cnt++;
    end
    chk("midrst_quiet", cnt, 0);
    $display("reset during clear");

    run_op(2'd1, '0, 1'b0, 1'b0, busy_n, done_k, first_we, seq_bad, rdy_bad);
    chk("clr2_first_we", first_we, 2);
    chk("clr2_done_at", done_k, N + 2);
    cmp_once("clr2_once");
    for (int i = 0; i < N; i++) exp_mem[i] = '0;
    cmp_mem("clr2_mem");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
